// File: rtl/lab2_proc_int_mul_pkg.sv
// ============================================================================
//  Module  : lab2_proc_int_mul_pkg
//  Brief   : Shared types and constants for the iterative integer multiplier.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package lab2_proc_int_mul_pkg;

    localparam int C_NBITS   = 32;
    localparam int C_COUNT_W = $clog2(C_NBITS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [C_NBITS-1:0] a;
        logic [C_NBITS-1:0] b;
    } mul_req_msg_t;

    // Iteration counter width for an arbitrary operand width (at least one bit).
    function automatic int count_width(input int nbits);
        return (nbits > 1) ? $clog2(nbits) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lab2_proc_int_mul_iter_dpath.sv
// ============================================================================
//  Module  : lab2_proc_int_mul_iter_dpath
//  Brief   : Shift-add datapath: operand shifters, accumulator and counter.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lab2_proc_int_mul_iter_dpath
    import lab2_proc_int_mul_pkg::*;
#(
    parameter int p_nbits = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               calc,
    input  logic               add_en,
    input  logic [p_nbits-1:0] a_in,
    input  logic [p_nbits-1:0] b_in,
    output logic               b_lsb,
    output logic               b_next_zero,
    output logic               count_done,
    output logic [p_nbits-1:0] result
);

    localparam int COUNT_W = count_width(p_nbits);

    logic [p_nbits-1:0] r_a;
    logic [p_nbits-1:0] r_b;
    logic [p_nbits-1:0] r_result;
    logic [COUNT_W-1:0] r_count;

    logic [p_nbits-1:0] w_sum;
    logic [p_nbits-1:0] w_result_mux;

    // Adder drops the carry: only the low word of the product is kept.
    assign w_sum        = r_result + r_a;
    assign w_result_mux = add_en ? w_sum : r_result;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_count  <= '0;
        end else if (load) begin
            r_a      <= a_in;
            r_b      <= b_in;
            r_result <= '0;
            r_count  <= '0;
        end else if (calc) begin
            r_a      <= r_a << 1;
            r_b      <= r_b >> 1;
            r_result <= w_result_mux;
            r_count  <= r_count + COUNT_W'(1);
        end
    end

    assign b_lsb       = r_b[0];
    assign b_next_zero = ((r_b >> 1) == '0);
    assign count_done  = (r_count == COUNT_W'(p_nbits - 1));
    assign result      = r_result;

endmodule

`default_nettype wire

// File: rtl/lab2_proc_int_mul_iter.sv
// ============================================================================
//  Module  : lab2_proc_int_mul_iter
//  Brief   : Iterative shift-add multiplier with val/rdy request and response.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lab2_proc_int_mul_iter
    import lab2_proc_int_mul_pkg::*;
#(
    parameter int p_nbits      = 32,
    parameter bit p_early_exit = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_val,
    output logic                 req_rdy,
    input  logic [2*p_nbits-1:0] req_msg,
    output logic                 resp_val,
    input  logic                 resp_rdy,
    output logic [p_nbits-1:0]   resp_msg,
    output logic                 busy
);

    state_t r_state;
    logic   r_req_rdy;
    logic   r_resp_val;
    logic   r_busy;

    logic [p_nbits-1:0] w_req_a;
    logic [p_nbits-1:0] w_req_b;
    logic [p_nbits-1:0] w_result;
    logic               w_b_lsb;
    logic               w_b_next_zero;
    logic               w_count_done;
    logic               w_load;
    logic               w_calc;
    logic               w_add_en;
    logic               w_calc_last;

    generate
        if (p_nbits == C_NBITS) begin : g_req_struct
            mul_req_msg_t w_req;
            assign w_req   = req_msg;
            assign w_req_a = w_req.a;
            assign w_req_b = w_req.b;
        end else begin : g_req_slice
            assign w_req_a = req_msg[2*p_nbits-1:p_nbits];
            assign w_req_b = req_msg[p_nbits-1:0];
        end
    endgenerate

    assign w_load      = req_val && r_req_rdy;
    assign w_calc      = (r_state == ST_CALC);
    assign w_add_en    = w_calc && w_b_lsb;
    assign w_calc_last = w_count_done || (p_early_exit && w_b_next_zero);

    lab2_proc_int_mul_iter_dpath #(
        .p_nbits (p_nbits)
    ) u_dpath (
        .clk         (clk),
        .reset       (reset),
        .load        (w_load),
        .calc        (w_calc),
        .add_en      (w_add_en),
        .a_in        (w_req_a),
        .b_in        (w_req_b),
        .b_lsb       (w_b_lsb),
        .b_next_zero (w_b_next_zero),
        .count_done  (w_count_done),
        .result      (w_result)
    );

    // Output flags are registered alongside the state so they never depend on inputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_req_rdy  <= 1'b1;
            r_resp_val <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_val) begin
                        r_state    <= ST_CALC;
                        r_req_rdy  <= 1'b0;
                        r_resp_val <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                ST_CALC: begin
                    if (w_calc_last) begin
                        r_state    <= ST_DONE;
                        r_req_rdy  <= 1'b0;
                        r_resp_val <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (resp_rdy) begin
                        r_state    <= ST_IDLE;
                        r_req_rdy  <= 1'b1;
                        r_resp_val <= 1'b0;
                        r_busy     <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_req_rdy  <= 1'b1;
                    r_resp_val <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    // Holding reset forces every output quiet, even before the first reset edge.
    assign req_rdy  = reset && r_req_rdy;
    assign resp_val = reset && r_resp_val;
    assign busy     = reset && r_busy;
    assign resp_msg = {p_nbits{resp_val}} & w_result;

endmodule

`default_nettype wire
